// File: rtl/sram_read_sequencer.sv
// SRAM read sequencer: precharge, wordline develop, sense-amp fire,
// then differential decode of the sense-amp row into read data.
module sram_read_sequencer #(
    parameter int W       = 8,
    parameter int AW      = 6,
    parameter int PCH_CYC = 2,
    parameter int DEV_CYC = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic          ready,
    output logic          busy,
    output logic          pch_en,
    output logic          wl_en,
    output logic [AW-1:0] row,
    output logic          sae,
    input  logic [W-1:0]  sa_out,
    input  logic [W-1:0]  sa_outn,
    output logic [W-1:0]  rdata,
    output logic          rvalid,
    output logic [W-1:0]  rerr
);

    generate
        if (PCH_CYC < 1 || PCH_CYC > 15) begin : g_bad_pch
            $error("PCH_CYC must be in 1..15");
        end
        if (DEV_CYC < 1 || DEV_CYC > 15) begin : g_bad_dev
            $error("DEV_CYC must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PCH   = 3'd1,
        DEV   = 3'd2,
        SENSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic pch_nxt;
    logic wl_nxt;
    logic sae_nxt;
    logic rvalid_nxt;
    logic ready_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    next_state = PCH;
                    cnt_nxt    = 4'(PCH_CYC - 1);
                end
            end
            PCH: begin
                if (cnt == 4'd0) begin
                    next_state = DEV;
                    cnt_nxt    = 4'(DEV_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DEV: begin
                if (cnt == 4'd0) begin
                    next_state = SENSE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SENSE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Enables are decoded from the next state and flopped, so they
    // leave the block straight from registers with no decode glitches.
    always_comb begin
        pch_nxt    = (next_state == PCH);
        wl_nxt     = (next_state == DEV);
        sae_nxt    = (next_state == SENSE);
        rvalid_nxt = (next_state == DONE);
        ready_nxt  = (next_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pch_en <= 1'b0;
            wl_en  <= 1'b0;
            sae    <= 1'b0;
            rvalid <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            pch_en <= pch_nxt;
            wl_en  <= wl_nxt;
            sae    <= sae_nxt;
            rvalid <= rvalid_nxt;
            ready  <= ready_nxt;
            busy   <= !ready_nxt;
        end
    end

    // A column resolves only when exactly one rail of the pair is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row   <= '0;
            rdata <= '0;
            rerr  <= '0;
        end else begin
            if (state == IDLE && req) begin
                row <= addr;
            end
            if (state == SENSE) begin
                rdata <= sa_out & ~sa_outn;
                rerr  <= ~(sa_out ^ sa_outn);
            end
        end
    end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Bench for sram_read_sequencer: directed scenarios then random traffic,
// all checked against a timeline model of each accepted read.
module tb_sram_read_sequencer;

    localparam int W  = 8;
    localparam int AW = 6;
    localparam int P  = 2;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [AW-1:0] addr;
    logic          ready;
    logic          busy;
    logic          pch_en;
    logic          wl_en;
    logic [AW-1:0] row;
    logic          sae;
    logic [W-1:0]  sa_out;
    logic [W-1:0]  sa_outn;
    logic [W-1:0]  rdata;
    logic          rvalid;
    logic [W-1:0]  rerr;

    sram_read_sequencer #(.W(W), .AW(AW), .PCH_CYC(P), .DEV_CYC(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .ready   (ready),
        .busy    (busy),
        .pch_en  (pch_en),
        .wl_en   (wl_en),
        .row     (row),
        .sae     (sae),
        .sa_out  (sa_out),
        .sa_outn (sa_outn),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rerr    (rerr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: an accepted read is a fixed timeline measured from the
    // accept edge; phase p counts cycles after that edge (p=1 first).
    int            n      = 0;
    int            acc    = 0;
    bit            active = 1'b0;
    logic [AW-1:0] row_m   = '0;
    logic [W-1:0]  rdata_m = '0;
    logic [W-1:0]  rerr_m  = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, n, got, exp);
        end
    endtask

    task automatic step();
        int ph;
        @(posedge clk);
        if (!rst_n) begin
            active  = 1'b0;
            row_m   = '0;
            rdata_m = '0;
            rerr_m  = '0;
        end else if (active) begin
            if (n - acc == P + D + 1) begin
                for (int i = 0; i < W; i++) begin
                    case ({sa_out[i], sa_outn[i]})
                        2'b10:   begin rdata_m[i] = 1'b1; rerr_m[i] = 1'b0; end
                        2'b01:   begin rdata_m[i] = 1'b0; rerr_m[i] = 1'b0; end
                        default: begin rdata_m[i] = 1'b0; rerr_m[i] = 1'b1; end
                    endcase
                end
            end else if (n - acc == P + D + 2) begin
                active = 1'b0;
            end
        end else if (req) begin
            active = 1'b1;
            acc    = n;
            row_m  = addr;
        end
        #1;
        ph = n - acc + 1;
        check("pch_en", 32'(pch_en), 32'(active && ph >= 1 && ph <= P));
        check("wl_en", 32'(wl_en), 32'(active && ph > P && ph <= P + D));
        check("sae", 32'(sae), 32'(active && ph == P + D + 1));
        check("rvalid", 32'(rvalid), 32'(active && ph == P + D + 2));
        check("busy", 32'(busy), 32'(active));
        check("ready", 32'(ready), 32'(!active));
        check("row", 32'(row), 32'(row_m));
        check("rdata", 32'(rdata), 32'(rdata_m));
        check("rerr", 32'(rerr), 32'(rerr_m));
        check("onehot", 32'($countones({pch_en, wl_en, sae}) <= 1), 32'd1);
        n++;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 1'b1;
        addr    = 6'h15;
        sa_out  = 8'hA5;
        sa_outn = 8'h5A;
        repeat (2) step();

        // basic read, accepted on the first edge out of reset
        rst_n = 1'b1;
        step();
        req = 1'b0;
        repeat (P + D + 2) step();
        check("basic_rdata", 32'(rdata), 32'h0000_00A5);
        check("basic_rerr", 32'(rerr), 32'h0000_0000);
        check("basic_row", 32'(row), 32'h0000_0015);

        // unresolved columns
        sa_out  = 8'h0F;
        sa_outn = 8'h3C;
        addr    = 6'h07;
        req     = 1'b1;
        step();
        req = 1'b0;
        repeat (P + D + 3) step();
        check("unres_rdata", 32'(rdata), 32'h0000_0003);
        check("unres_rerr", 32'(rerr), 32'h0000_00CC);

        // back-to-back with a new address applied mid-read
        sa_out  = 8'h3C;
        sa_outn = 8'hC3;
        addr    = 6'h2A;
        req     = 1'b1;
        step();
        addr = 6'h11;
        repeat (2 * (P + D + 3)) step();
        req = 1'b0;
        repeat (2) step();
        check("b2b_row", 32'(row), 32'h0000_0011);

        // reset during develop
        addr = 6'h33;
        req  = 1'b1;
        step();
        req = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("rst_wl", 32'(wl_en), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (P + D + 3) step();
        check("rst_ready", 32'(ready), 32'd1);

        // random traffic with occasional resets
        for (int c = 0; c < 10000; c++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            req     = ($urandom_range(0, 3) != 0);
            addr    = AW'($urandom);
            sa_out  = W'($urandom);
            sa_outn = W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
